// File: rtl/sound_arbiter.sv
// sound_arbiter: priority arbiter for asynchronous sound requests.
// Each request is synchronized, edge-detected and queued as pending. The
// highest pending channel plays its code for HOLD_CYCLES clocks. A higher
// channel preempts the current sound, and a fresh edge on the playing
// channel restarts its hold time.
module sound_arbiter #(
    parameter int NUM_CHANNELS = 4,
    parameter int CODE_W       = 4,
    parameter int HOLD_CYCLES  = 5_000_000,
    parameter logic [NUM_CHANNELS*CODE_W-1:0] SOUND_CODES = {4'h9, 4'h5, 4'hD, 4'h1},
    parameter logic [CODE_W-1:0] SILENCE_CODE = '0
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            enable,
    input  logic [NUM_CHANNELS-1:0]         sound_requests,
    output logic [CODE_W-1:0]               sound_signal,
    output logic                            sound_active,
    output logic [$clog2(NUM_CHANNELS)-1:0] active_channel
);

    localparam int CH_W  = $clog2(NUM_CHANNELS);
    localparam int CNT_W = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {IDLE, PLAY} state_t;

    logic [NUM_CHANNELS-1:0] r_sync1, r_sync2, r_prev, r_edge, r_pending;
    logic [NUM_CHANNELS-1:0] w_edge, w_cand, w_pending_nx;
    logic [CH_W-1:0]         r_ch, w_ch_nx, w_winner;
    logic [CNT_W-1:0]        r_cnt, w_cnt_nx;
    logic [CODE_W-1:0]       r_code, w_code_nx;
    logic                    r_active;
    logic                    w_any, w_load, w_idle;
    state_t                  r_state, w_state_nx;

    // Rising edge: synchronized level high while the previous sample was low.
    assign w_edge = r_sync2 & ~r_prev;
    assign w_cand = r_pending | r_edge;
    assign w_any  = |w_cand;

    // Two-flop synchronizer, history flop, and registered edge pulses.
    // Edges seen while disabled are dropped here so they never reach the FSM.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_edge  <= '0;
        end else begin
            r_sync1 <= sound_requests;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_edge  <= w_edge & {NUM_CHANNELS{enable}};
        end
    end

    // Winner select: highest-index candidate wins.
    always_comb begin
        w_winner = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_cand[i]) w_winner = CH_W'(i);
        end
    end

    // Next-state logic: load / preempt / retrigger / expire decisions.
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_code_nx    = r_code;
        w_ch_nx      = r_ch;
        w_pending_nx = r_pending | r_edge;
        w_load       = 1'b0;
        w_idle       = 1'b0;

        if (!enable) begin
            w_idle       = 1'b1;
            w_pending_nx = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) w_load = 1'b1;
                end
                PLAY: begin
                    // An edge on the playing channel retriggers it, never queues it.
                    w_pending_nx[r_ch] = r_pending[r_ch];
                    if (w_any && (w_winner > r_ch)) begin
                        w_load = 1'b1;
                    end else if (r_edge[r_ch]) begin
                        w_cnt_nx = CNT_LOAD;
                    end else if (r_cnt == '0) begin
                        if (w_any) w_load = 1'b1;
                        else       w_idle = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt - 1'b1;
                    end
                end
                default: w_idle = 1'b1;
            endcase
        end

        if (w_load) begin
            w_state_nx             = PLAY;
            w_code_nx              = SOUND_CODES[int'(w_winner)*CODE_W +: CODE_W];
            w_ch_nx                = w_winner;
            w_cnt_nx               = CNT_LOAD;
            w_pending_nx[w_winner] = 1'b0;
        end else if (w_idle) begin
            w_state_nx = IDLE;
            w_code_nx  = SILENCE_CODE;
            w_ch_nx    = '0;
            w_cnt_nx   = '0;
        end
    end

    // State, counter, pending set and registered outputs.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_code    <= SILENCE_CODE;
            r_ch      <= '0;
            r_active  <= 1'b0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_code    <= w_code_nx;
            r_ch      <= w_ch_nx;
            r_active  <= (w_state_nx == PLAY);
            r_pending <= w_pending_nx;
        end
    end

    assign sound_signal   = r_code;
    assign sound_active   = r_active;
    assign active_channel = r_ch;

endmodule

// File: tb/tb_sound_arbiter.sv
// tb_sound_arbiter: scenario bench for sound_arbiter with HOLD_CYCLES=8.
// Scenario tasks push expected bursts (start tick, code, length, channel);
// a negedge monitor segments sound_signal into bursts and pops/compares.
module tb_sound_arbiter;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       enable = 1'b1;
    logic [3:0] sound_requests = 4'b0000;
    logic [3:0] sound_signal;
    logic       sound_active;
    logic [1:0] active_channel;

    int n_cmp  = 0;
    int n_fail = 0;
    int tick   = 0;

    typedef struct {
        int         start;
        logic [3:0] code;
        int         len;
        int         ch;
    } burst_t;

    burst_t exp_q[$];

    logic       mon_on   = 1'b0;
    logic       mon_prev = 1'b0;
    logic [3:0] run_code;
    int         run_start, run_len, run_ch;
    bit         run_ch_ok;
    burst_t     e;

    sound_arbiter #(
        .NUM_CHANNELS(4),
        .CODE_W(4),
        .HOLD_CYCLES(8),
        .SOUND_CODES({4'h9, 4'h5, 4'hD, 4'h1}),
        .SILENCE_CODE(4'h0)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .enable(enable),
        .sound_requests(sound_requests),
        .sound_signal(sound_signal),
        .sound_active(sound_active),
        .active_channel(active_channel)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    function automatic burst_t mk(int start, logic [3:0] code, int len, int ch);
        burst_t b;
        b.start = start;
        b.code  = code;
        b.len   = len;
        b.ch    = ch;
        return b;
    endfunction

    // Burst monitor / scoreboard
    always @(negedge clk) begin
        if (mon_on) begin
            if (!mon_prev) begin
                run_code = 4'h0;
                run_len  = 0;
            end
            n_cmp++;
            if (sound_active !== (sound_signal != 4'h0)) begin
                n_fail++;
                $display("FAIL active_flag tick=%0d sound_active=%b sound_signal=%h", tick, sound_active, sound_signal);
            end
            if (sound_signal == 4'h0) begin
                n_cmp++;
                if (active_channel !== 2'd0) begin
                    n_fail++;
                    $display("FAIL idle_channel tick=%0d active_channel=%0d expected=0", tick, active_channel);
                end
            end
            if (sound_signal !== run_code) begin
                if (run_code != 4'h0) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_burst code=%h start=%0d len=%0d ch=%0d expected=none",
                                 run_code, run_start, run_len, run_ch);
                    end else begin
                        e = exp_q.pop_front();
                        if (run_code !== e.code || run_start != e.start || run_len != e.len ||
                            run_ch != e.ch || !run_ch_ok) begin
                            n_fail++;
                            $display("FAIL burst got code=%h start=%0d len=%0d ch=%0d ch_stable=%0d expected code=%h start=%0d len=%0d ch=%0d",
                                     run_code, run_start, run_len, run_ch, run_ch_ok, e.code, e.start, e.len, e.ch);
                        end
                    end
                end
                run_code  = sound_signal;
                run_start = tick;
                run_len   = 1;
                run_ch    = int'(active_channel);
                run_ch_ok = 1'b1;
            end else begin
                run_len++;
                if (int'(active_channel) != run_ch) run_ch_ok = 1'b0;
            end
        end
        mon_prev = mon_on;
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (sound_signal !== 4'h0)  begin n_fail++; $display("FAIL reset_signal got=%h expected=0", sound_signal); end
        n_cmp++; if (sound_active !== 1'b0)  begin n_fail++; $display("FAIL reset_active got=%b expected=0", sound_active); end
        n_cmp++; if (active_channel !== 2'd0) begin n_fail++; $display("FAIL reset_channel got=%0d expected=0", active_channel); end
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (sound_signal !== 4'h0) begin n_fail++; $display("FAIL post_reset_signal got=%h expected=0", sound_signal); end
        n_cmp++; if (sound_active !== 1'b0) begin n_fail++; $display("FAIL post_reset_active got=%b expected=0", sound_active); end
        mon_on = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int t;
        @(negedge clk);
        t = tick;
        sound_requests = 4'b0001;
        exp_q.push_back(mk(t + 4, 4'h1, 8, 0));
        @(negedge clk);
        sound_requests = 4'b0000;
        repeat (20) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_pending got=%0d expected=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_preempt();
        int t;
        @(negedge clk);
        t = tick;
        sound_requests = 4'b0001;
        exp_q.push_back(mk(t + 4, 4'h1, 6, 0));
        @(negedge clk);
        sound_requests = 4'b0000;
        repeat (5) @(negedge clk);
        sound_requests = 4'b0010;
        exp_q.push_back(mk(t + 10, 4'hD, 8, 1));
        @(negedge clk);
        sound_requests = 4'b0000;
        repeat (25) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL preempt_pending got=%0d expected=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_same_cycle();
        int t;
        @(negedge clk);
        t = tick;
        sound_requests = 4'b1010;
        exp_q.push_back(mk(t + 4,  4'h9, 8, 3));
        exp_q.push_back(mk(t + 12, 4'hD, 8, 1));
        @(negedge clk);
        sound_requests = 4'b0000;
        repeat (28) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL same_cycle_pending got=%0d expected=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_held_level();
        int t;
        @(negedge clk);
        t = tick;
        sound_requests = 4'b0100;
        exp_q.push_back(mk(t + 4, 4'h5, 8, 2));
        repeat (40) @(negedge clk);
        sound_requests = 4'b0000;
        repeat (10) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL held_pending got=%0d expected=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_retrigger();
        int t;
        @(negedge clk);
        t = tick;
        sound_requests = 4'b0100;
        // second pulse at t+5 reloads the counter at tick t+9; last code tick is t+16
        exp_q.push_back(mk(t + 4, 4'h5, 13, 2));
        @(negedge clk);
        sound_requests = 4'b0000;
        repeat (4) @(negedge clk);
        sound_requests = 4'b0100;
        @(negedge clk);
        sound_requests = 4'b0000;
        repeat (20) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL retrigger_pending got=%0d expected=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_enable();
        int t;
        @(negedge clk);
        t = tick;
        sound_requests = 4'b0100;
        exp_q.push_back(mk(t + 4, 4'h5, 5, 2));
        @(negedge clk);
        sound_requests = 4'b0000;
        @(negedge clk);
        sound_requests = 4'b0010;
        @(negedge clk);
        sound_requests = 4'b0000;
        repeat (5) @(negedge clk);
        enable = 1'b0;
        sound_requests = 4'b0001;
        @(negedge clk);
        n_cmp++; if (sound_signal !== 4'h0) begin n_fail++; $display("FAIL disable_signal got=%h expected=0", sound_signal); end
        n_cmp++; if (sound_active !== 1'b0) begin n_fail++; $display("FAIL disable_active got=%b expected=0", sound_active); end
        repeat (4) @(negedge clk);
        enable = 1'b1;
        repeat (20) @(negedge clk);
        sound_requests = 4'b0000;
        repeat (5) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL enable_pending got=%0d expected=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_midplay();
        int t;
        int r;
        @(negedge clk);
        t = tick;
        sound_requests = 4'b0001;
        exp_q.push_back(mk(t + 4, 4'h1, 3, 0));
        repeat (6) @(negedge clk);
        #2 resetN = 1'b0;
        #1;
        n_cmp++; if (sound_signal !== 4'h0)   begin n_fail++; $display("FAIL async_reset_signal got=%h expected=0", sound_signal); end
        n_cmp++; if (sound_active !== 1'b0)   begin n_fail++; $display("FAIL async_reset_active got=%b expected=0", sound_active); end
        n_cmp++; if (active_channel !== 2'd0) begin n_fail++; $display("FAIL async_reset_channel got=%0d expected=0", active_channel); end
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        r = tick;
        exp_q.push_back(mk(r + 4, 4'h1, 8, 0));
        repeat (15) @(negedge clk);
        sound_requests = 4'b0000;
        repeat (5) @(negedge clk);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL reset_midplay_pending got=%0d expected=0", exp_q.size()); end
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_preempt();
        test_same_cycle();
        test_held_level();
        test_retrigger();
        test_enable();
        test_reset_midplay();
        mon_on = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/sound_arbiter.md
SOUND_ARBITER -- requirements
Module: sound_arbiter

Interface
- REQ-001 The block SHALL have parameter NUM_CHANNELS, default 4: the number of request channels (2..16).
- REQ-002 The block SHALL have parameter CODE_W, default 4: the width of a sound code.
- REQ-003 The block SHALL have parameter HOLD_CYCLES, default 5_000_000: the number of clk cycles a sound plays (at least 2).
- REQ-004 The block SHALL have parameter SOUND_CODES, a packed NUM_CHANNELS*CODE_W array, default {4'h9,4'h5,4'hD,4'h1}: the code for channel i is slice i.
- REQ-005 The block SHALL have parameter SILENCE_CODE, default 0: the code driven when nothing plays.
- REQ-006 The block SHALL have port clk, input, 1 bit: the system clock.
- REQ-007 The block SHALL have port resetN, input, 1 bit: asynchronous, active-low reset.
- REQ-008 The block SHALL have port enable, input, 1 bit: the sound master enable, synchronous to clk.
- REQ-009 The block SHALL have port sound_requests, input, NUM_CHANNELS bits: one request per channel, asynchronous; a higher index has higher priority.
- REQ-010 The block SHALL have port sound_signal, output, CODE_W bits: the code sent to the audio unit.
- REQ-011 The block SHALL have port sound_active, output, 1 bit: high while in state PLAY.
- REQ-012 The block SHALL have port active_channel, output, $clog2(NUM_CHANNELS) bits: the index of the playing channel, and 0 when idle.

Function
- REQ-013 Each request bit SHALL pass through a 2-flop synchronizer; a third flop holds the previous synchronized value.
- REQ-014 A rising edge on channel i SHALL be defined as synchronized value 1 with previous value 0; a level held high SHALL produce exactly one edge.
- REQ-015 An edge SHALL set pending[i]; an edge on a channel whose pending bit is already set SHALL have no further effect (requests are not counted).
- REQ-016 The candidate set SHALL be pending OR the current-cycle edges; the winner SHALL be the highest set index.
- REQ-017 The FSM SHALL have two states, IDLE and PLAY, plus a hold counter of width $clog2(HOLD_CYCLES).
- REQ-018 IDLE to PLAY: when the candidate set is non-empty, the block SHALL load the winner's code, set active_channel to the winner, clear that pending bit, and load the counter with HOLD_CYCLES-1.
- REQ-019 In PLAY, the counter SHALL decrement once per cycle.
- REQ-020 In PLAY, preemption: if the winner index is greater than active_channel, the block SHALL switch to it immediately, clear its pending bit, and reload the counter. The preempted channel SHALL NOT be re-queued.
- REQ-021 In PLAY, retrigger: an edge on active_channel SHALL reload the counter without setting its pending bit.
- REQ-022 In PLAY with counter 0 and candidates present, the block SHALL load the winner as in REQ-018 with no silent gap cycle.
- REQ-023 In PLAY with counter 0 and no candidates, the block SHALL go to IDLE, drive SILENCE_CODE, and set active_channel to 0.
- REQ-024 Latency: for a request that goes high and is sampled at clk edge k with the block idle, sound_signal SHALL show the code after edge k+3.
- REQ-025 Each sound SHALL last exactly HOLD_CYCLES cycles unless it is preempted or retriggered.
- REQ-026 All outputs SHALL be registered.
- REQ-027 When enable is low, the block SHALL go to IDLE on the next edge, drive SILENCE_CODE, clear all pending bits, and ignore edges. The synchronizers SHALL keep running, so a level held across enable rising SHALL NOT produce an edge.
- REQ-028 If edges arrive on several channels in the same cycle, the highest index SHALL be served first and the others SHALL stay pending, served in descending index order.

Reset
- REQ-029 On resetN low, asynchronously: sound_signal SHALL be SILENCE_CODE, sound_active 0, active_channel 0, state IDLE, counter 0, and all pending and synchronizer flops 0.
- REQ-030 A reset asserted during PLAY SHALL abort the sound immediately; after release, a request bit already high SHALL count as a new rising edge.

Verification (NUM_CHANNELS=4, CODE_W=4, HOLD_CYCLES=8, default codes)
- REQ-031 A pulse on req[0] at edge k -> sound_signal=1 after edge k+3, held for 8 cycles, then 0; sound_active high for exactly 8 cycles.
- REQ-032 req[0] playing, then req[1] pulse -> sound_signal switches to D 3 cycles after the pulse, plays 8 cycles, then 0; channel 0 is not resumed.
- REQ-033 req[3] and req[1] rise in the same cycle -> 9 for 8 cycles, then D for 8 cycles with no gap, then 0.
- REQ-034 req[2] held high for 40 cycles -> exactly one 8-cycle burst of code 5; a second pulse during play extends the sound to 8 cycles after the retrigger.
- REQ-035 enable dropped mid-play with req[1] pending -> silence on the next edge; on re-enable with no new edges, output stays 0.
- REQ-036 resetN pulsed low mid-play -> all outputs 0 asynchronously; with req[0] held high through release, code 1 appears 3 cycles after release.
